// File: rtl/ball_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ball_pkg
//  Purpose  : Shared types and defaults for the ball motion controller.
//  Revision : 1.0  initial release
// ============================================================================
package ball_pkg;

    localparam int C_H_RES_DEF = 640;
    localparam int C_V_RES_DEF = 480;
    localparam int C_COORD_W   = 10;

    typedef logic [C_COORD_W-1:0]      coord_t;
    typedef logic signed [C_COORD_W:0] coord_s_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ball_axis_step.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ball_axis_step
//  Purpose  : Combinational one-axis move with edge clamp and bounce.
//  Revision : 1.0  initial release
// ============================================================================
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int RADIUS = 40
) (
    input  coord_t     pos,
    input  logic       dir,
    input  logic [3:0] speed,
    input  coord_t     limit,
    output coord_t     new_pos,
    output logic       new_dir,
    output logic       bounce
);

    coord_s_t w_next;
    coord_s_t w_hi;
    coord_s_t w_lo;
    coord_s_t w_clamp_hi;

    // dir = 0 moves toward larger coordinates, dir = 1 toward smaller
    always_comb begin
        w_hi       = $signed({1'b0, limit}) - coord_s_t'(RADIUS);
        w_lo       = coord_s_t'(RADIUS);
        w_clamp_hi = w_hi - 11'sd1;
        if (dir) begin
            w_next = $signed({1'b0, pos}) - $signed({7'd0, speed});
        end else begin
            w_next = $signed({1'b0, pos}) + $signed({7'd0, speed});
        end
        new_pos = w_next[9:0];
        new_dir = dir;
        bounce  = 1'b0;
        if (w_next >= w_hi) begin
            new_pos = w_clamp_hi[9:0];
            new_dir = 1'b1;
            bounce  = 1'b1;
        end else if (w_next < w_lo) begin
            new_pos = w_lo[9:0];
            new_dir = 1'b0;
            bounce  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ball_motion_ctrl
//  Purpose  : Per-frame sequenced motion update for NUM_BALLS sprites with
//             atomic publication of all positions.
//  Revision : 1.0  initial release
// ============================================================================
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int NUM_BALLS     = 2,
    parameter int H_RES         = C_H_RES_DEF,
    parameter int V_RES         = C_V_RES_DEF,
    parameter int RADIUS        = 40,
    parameter int INIT_X        = 320,
    parameter int INIT_Y        = 200,
    parameter int SPACING       = 100,
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   v_sync,
    input  logic                   run,
    input  logic                   step,
    input  logic [3:0]             speed,
    output logic [10*NUM_BALLS-1:0] ball_x,
    output logic [10*NUM_BALLS-1:0] ball_y,
    output logic                   busy,
    output logic                   frame_done,
    output logic [NUM_BALLS-1:0]   edge_hit,
    output logic                   overrun
);

    localparam int                 c_idx_w   = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(NUM_BALLS - 1);
    localparam coord_t             c_h_lim   = coord_t'(H_RES);
    localparam coord_t             c_v_lim   = coord_t'(V_RES);
    localparam logic               c_vs_idle = (VS_ACTIVE_LOW != 0);

    logic                   r_vs_meta, r_vs_sync, r_vs_prev, r_tick;
    logic                   w_vs_act, w_vs_prev_act;
    state_t                 r_state;
    logic [c_idx_w-1:0]     r_idx;
    coord_t                 r_work_x [NUM_BALLS];
    coord_t                 r_work_y [NUM_BALLS];
    logic [NUM_BALLS-1:0]   r_dir_x, r_dir_y;
    coord_t                 r_cur_x, r_cur_y;
    logic                   r_cur_dx, r_cur_dy;
    logic [3:0]             r_speed;
    coord_t                 r_nx, r_ny;
    logic                   r_ndx, r_ndy, r_bounce;
    logic [NUM_BALLS-1:0]   r_hit_acc;
    logic                   r_step_armed;
    logic [10*NUM_BALLS-1:0] r_ball_x, r_ball_y;
    logic                   r_busy, r_frame_done, r_overrun;
    logic [NUM_BALLS-1:0]   r_edge_hit;

    coord_t                 w_nx, w_ny;
    logic                   w_ndx, w_ndy, w_bx, w_by;
    logic [NUM_BALLS-1:0]   w_hit_now;

    assign w_vs_act      = c_vs_idle ? ~r_vs_sync : r_vs_sync;
    assign w_vs_prev_act = c_vs_idle ? ~r_vs_prev : r_vs_prev;
    assign w_hit_now     = NUM_BALLS'(r_bounce) << r_idx;

    ball_axis_step #(.RADIUS(RADIUS)) u_step_x (
        .pos     (r_cur_x),
        .dir     (r_cur_dx),
        .speed   (r_speed),
        .limit   (c_h_lim),
        .new_pos (w_nx),
        .new_dir (w_ndx),
        .bounce  (w_bx)
    );

    ball_axis_step #(.RADIUS(RADIUS)) u_step_y (
        .pos     (r_cur_y),
        .dir     (r_cur_dy),
        .speed   (r_speed),
        .limit   (c_v_lim),
        .new_pos (w_ny),
        .new_dir (w_ndy),
        .bounce  (w_by)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_meta    <= c_vs_idle;
            r_vs_sync    <= c_vs_idle;
            r_vs_prev    <= c_vs_idle;
            r_tick       <= 1'b0;
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_cur_dx     <= 1'b0;
            r_cur_dy     <= 1'b0;
            r_speed      <= '0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_ndx        <= 1'b0;
            r_ndy        <= 1'b0;
            r_bounce     <= 1'b0;
            r_hit_acc    <= '0;
            r_step_armed <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_edge_hit   <= '0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_work_x[i]          <= coord_t'(INIT_X + i * SPACING);
                r_work_y[i]          <= coord_t'(INIT_Y);
                r_ball_x[10*i +: 10] <= coord_t'(INIT_X + i * SPACING);
                r_ball_y[10*i +: 10] <= coord_t'(INIT_Y);
                r_dir_x[i]           <= 1'((i % 2) != 0);
                r_dir_y[i]           <= 1'b0;
            end
        end else begin
            r_vs_meta    <= v_sync;
            r_vs_sync    <= r_vs_meta;
            r_vs_prev    <= r_vs_sync;
            r_tick       <= w_vs_act & ~w_vs_prev_act;
            r_frame_done <= 1'b0;
            r_edge_hit   <= '0;

            if (step && !run) begin
                r_step_armed <= 1'b1;
            end
            if (r_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_tick && (run || r_step_armed)) begin
                        r_state      <= ST_LOAD;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_hit_acc    <= '0;
                        r_step_armed <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_cur_x  <= r_work_x[r_idx];
                    r_cur_y  <= r_work_y[r_idx];
                    r_cur_dx <= r_dir_x[r_idx];
                    r_cur_dy <= r_dir_y[r_idx];
                    r_speed  <= speed;
                    r_state  <= ST_CALC;
                end
                ST_CALC: begin
                    r_nx     <= w_nx;
                    r_ny     <= w_ny;
                    r_ndx    <= w_ndx;
                    r_ndy    <= w_ndy;
                    r_bounce <= w_bx | w_by;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_work_x[r_idx] <= r_nx;
                    r_work_y[r_idx] <= r_ny;
                    r_dir_x[r_idx]  <= r_ndx;
                    r_dir_y[r_idx]  <= r_ndy;
                    if (r_idx == c_last) begin
                        // Publish on the edge into COMMIT so the pulses and the
                        // new positions appear in the same cycle.
                        for (int j = 0; j < NUM_BALLS - 1; j++) begin
                            r_ball_x[10*j +: 10] <= r_work_x[j];
                            r_ball_y[10*j +: 10] <= r_work_y[j];
                        end
                        r_ball_x[10*(NUM_BALLS-1) +: 10] <= r_nx;
                        r_ball_y[10*(NUM_BALLS-1) +: 10] <= r_ny;
                        r_edge_hit   <= r_hit_acc | w_hit_now;
                        r_frame_done <= 1'b1;
                        r_state      <= ST_COMMIT;
                    end else begin
                        r_hit_acc <= r_hit_acc | w_hit_now;
                        r_idx     <= r_idx + 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign edge_hit   = r_edge_hit;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Per-frame motion controller for up to NUM_BALLS bouncing sprites on the 640x480 VGA display.
- Detects the frame boundary from v_sync in the pixel-clock domain, then sequences a position/direction update for each ball through one shared update datapath.
- Publishes all positions atomically, so the downstream hit-test/colour renderer always sees one consistent frame.
- Replaces the free-running per-sprite v_sync-clocked motion logic. The renderer keeps only its combinational distance test.

Parameters:
- NUM_BALLS, 2, number of balls sequenced (1..8)
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- RADIUS, 40, ball radius used for edge detection
- INIT_X, 320, ball 0 initial x
- INIT_Y, 200, initial y, all balls
- SPACING, 100, x offset between consecutive balls at reset
- VS_ACTIVE_LOW, 1, 1 = v_sync pulse is active-low

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  synchronous active-low reset
- v_sync  in  1  vertical sync from the VGA sync generator (asynchronous to this logic, passes through a 2-flop synchroniser)
- run  in  1  1 = update every frame
- step  in  1  one-cycle pulse; when run=0, arms exactly one update at the next frame tick
- speed  in  4  pixels/frame magnitude, unsigned, sampled per ball in LOAD
- ball_x  out  10*NUM_BALLS  packed x positions, ball i at bits [10i+9:10i]
- ball_y  out  10*NUM_BALLS  packed y positions, same packing
- busy  out  1  update sequence in progress
- frame_done  out  1  one-cycle pulse, first cycle new positions are visible
- edge_hit  out  NUM_BALLS  one-cycle pulse per ball that bounced this frame, coincident with frame_done
- overrun  out  1  sticky; a frame tick arrived while busy

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ball i: x = INIT_X + i*SPACING, y = INIT_Y
  - dir_x = + for even i, - for odd i; dir_y = + for all
  - outputs equal the initial positions; busy, frame_done, edge_hit, overrun, step_armed all 0; FSM in IDLE
  - Reset asserted mid-sequence aborts the sequence with no frame_done and no partial publish.
- Frame tick:
  - One-cycle pulse on the active edge of synchronised v_sync (falling edge if VS_ACTIVE_LOW).
  - Latency from v_sync pin transition to tick is 3 clk.
- step handling: a step pulse with run=0 sets step_armed. It clears when consumed by a tick.
- Start condition: a tick in IDLE starts a sequence if run=1 or step_armed=1; otherwise the tick is ignored.
- A tick while busy is dropped and sets overrun. The sequence is never restarted.
- FSM: IDLE -> LOAD -> CALC -> WRITE, then LOAD for ball i+1 or COMMIT after the last ball -> IDLE.
  - LOAD: read working x, y, dir for ball i; latch speed.
  - CALC: compute next x and y in parallel.
  - WRITE: store working state for ball i; set that ball's bounce flag.
  - COMMIT: copy all working positions to the output registers; pulse frame_done and edge_hit.
- busy is high from the LOAD entry edge through the COMMIT cycle. Sequence length is 3*NUM_BALLS+1 cycles after the tick.
- Arithmetic: 11-bit signed intermediates.
  - nx = x + speed if dir_x=+, nx = x - speed if dir_x=-.
  - If nx + RADIUS >= H_RES: x = H_RES-1-RADIUS, dir_x = -, bounce.
  - Else if nx < RADIUS (signed, so underflow is caught): x = RADIUS, dir_x = +, bounce.
  - Else x = nx. Y uses the same rules with V_RES.
- Both axes bouncing in one frame gives a single edge_hit bit.
- speed=0: position unchanged, no bounce unless already outside bounds. Out-of-bounds positions are clamped.
- Outputs never glitch mid-frame. ball_x and ball_y change only on the COMMIT edge.

Decomposition:
- Package ball_pkg:
  - FSM state enum (IDLE, LOAD, CALC, WRITE, COMMIT)
  - H_RES/V_RES defaults, 10-bit coordinate typedef, 11-bit signed intermediate typedef
- Sub-module ball_axis_step: the combinational one-axis update.
  - Inputs: pos, dir, speed, limit, RADIUS.
  - Outputs: new pos, new dir, bounce.
  - Instantiated twice (x and y) in CALC.

Test Plan:
- Reset: rst_n=0 for 2 clk, NUM_BALLS=2 -> ball 0 (320,200), ball 1 (420,200); all flags 0.
- run=1, speed=4, one v_sync pulse -> frame_done 3+7 clk after the v_sync edge; ball 0 (324,204), ball 1 (416,204); edge_hit=00.
- 60 frames, speed=4:
  - ball 0 y reaches 440 >= 440 -> clamped to 439, edge_hit[0]=1 on frame 60.
  - frame 61 -> y=435.
- run=0, no step, 3 v_sync pulses -> positions unchanged, no frame_done.
- run=0, then step then 2 pulses -> exactly one update.
- Overrun:
  - Inject a second tick 2 clk after the first -> overrun=1, exactly one frame_done.
  - Then rst_n=0 while busy -> initial positions, no frame_done, overrun=0.
